// File: rtl/cpu_uart_tx.sv
// cpu_uart_tx: memory-mapped 8N1 serial transmitter on the CPU external bus.
// DATA (BASE_ADDR) stores push bytes into a small FIFO; STATUS (BASE_ADDR+1)
// reads {ie, 3'b000, ovf, busy, empty, full} and writes ie / clears ovf.
// The FIFO is drained LSB first onto tx by a START/DATA/STOP frame engine.
module cpu_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          DIVISOR    = 16,
  parameter int          DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic        mem_oe,
  input  logic        mem_we,
  output logic        tx,
  output logic        irq
);

  localparam int          PW     = DEPTH_LOG2 + 1;
  localparam int          DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [15:0] DIV_M1 = 16'(DIVISOR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Bus-side capture of store strobes
  logic          we_q;
  logic          armed;
  logic          wr_ev;
  logic          wr_sel;
  logic [7:0]    wr_data;

  // FIFO and control registers
  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ovf;
  logic          ie;

  // Transmit engine
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [15:0]   baud_cnt;

  logic          hit;
  logic          empty;
  logic          full;
  logic          busy;
  logic          pop;
  logic          push_req;
  logic          push_ok;

  assign hit      = (addr[15:1] == BASE_ADDR[15:1]);
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign busy     = (state != S_IDLE);
  assign pop      = (state == S_IDLE) && !empty;
  assign push_req = wr_ev && !wr_sel;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign irq      = ie && !full;
  assign d_oe     = hit && !mem_oe;

  // Read mux: STATUS returns flags, DATA reads as zero; no side effects.
  always_comb begin
    d_out = 8'h00;
    if (addr[0]) begin
      d_out = {ie, 3'b000, ovf, busy, empty, full};
    end else begin
      d_out = 8'h00;
    end
  end

  // Falling-edge detect of the store strobe; one registered event per strobe.
  // armed blocks the first post-reset cycle so a strobe held low across reset
  // release (we_q still at its reset value of 1) is not taken as a new write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b1;
      armed   <= 1'b0;
      wr_ev   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_data <= 8'h00;
    end else begin
      we_q    <= mem_we;
      armed   <= 1'b1;
      wr_ev   <= armed && !mem_we && we_q && hit;
      wr_sel  <= addr[0];
      wr_data <= d_in;
    end
  end

  // FIFO storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr[PW-2:0]] <= wr_data;
    end
  end

  // FIFO pointers, overflow flag and interrupt enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      ie     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_req && full && !pop) begin
        ovf <= 1'b1;
      end
      if (wr_ev && wr_sel) begin
        ie <= wr_data[7];
        if (wr_data[3]) begin
          ovf <= 1'b0;
        end
      end
    end
  end

  // Frame engine: pops a byte in IDLE, then START, 8 DATA bits, STOP.
  // tx is registered from the current state, so the line lags state by one clk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      shreg    <= 8'h00;
      bit_cnt  <= 3'd0;
      baud_cnt <= 16'd0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= shreg[0];
        default: tx <= 1'b1;
      endcase

      case (state)
        S_IDLE: begin
          if (!empty) begin
            shreg    <= fifo_mem[rd_ptr[PW-2:0]];
            baud_cnt <= DIV_M1;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= DIV_M1;
            bit_cnt  <= 3'd0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_cnt == 16'd0) begin
            baud_cnt <= DIV_M1;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (baud_cnt == 16'd0) begin
            state <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_uart_tx.sv
// Self-checking bench for cpu_uart_tx (DIVISOR=4, depth 4). A line monitor
// decodes frames from tx by mid-bit sampling; expectations come from the
// serial framing rules and a byte-queue model of what the CPU wrote.
module tb_cpu_uart_tx;

  localparam int          DIV   = 4;
  localparam int          DL2   = 2;
  localparam int          DEPTH = 1 << DL2;
  localparam logic [15:0] BASE  = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        mem_oe = 1'b1;
  logic        mem_we = 1'b1;
  logic        tx;
  logic        irq;

  cpu_uart_tx #(.BASE_ADDR(BASE), .DIVISOR(DIV), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .d_out(d_out),
    .d_oe(d_oe), .mem_oe(mem_oe), .mem_we(mem_we), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int width);
    addr   = a;
    d_in   = d;
    mem_we = 1'b0;
    repeat (width) tick();
    mem_we = 1'b1;
    tick();
  endtask

  task automatic check_status(input string name, input logic [7:0] exp);
    addr   = BASE + 16'd1;
    mem_oe = 1'b0;
    #1;
    check({name, " d_oe"}, {31'd0, d_oe}, 32'd1);
    check(name, {24'd0, d_out}, {24'd0, exp});
    mem_oe = 1'b1;
  endtask

  task automatic wait_rx(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (rx_q.size() < n) begin
      check({name, " timeout"}, rx_q.size(), n);
    end
  endtask

  // Line monitor: a low sample starts a frame; sample every bit at its centre.
  initial begin
    logic [7:0] b;
    int         t0;
    forever begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        t0 = cyc;
        repeat (DIV / 2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          #1;
          b[i] = tx;
        end
        repeat (DIV) @(posedge clk);
        #1;
        rx_q.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] a;
    logic        oe;
    logic        exp_doe;
    logic [7:0]  exp_dout;
  } rd_vec_t;

  initial begin
    rd_vec_t    tv[7];
    logic [7:0] exp_q[$];
    logic [7:0] fr_byte;
    logic       exp_tx;
    logic       tx_ok;
    logic       m_ie;
    int         k;
    int         n_acc;

    // Reset with a STATUS read in progress.
    rst = 1'b0; addr = BASE + 16'd1; mem_oe = 1'b0; mem_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset d_oe", {31'd0, d_oe}, 32'd1);
      check("reset status", {24'd0, d_out}, 32'h02);
      check("reset tx", {31'd0, tx}, 32'd1);
    end
    check("reset irq", {31'd0, irq}, 32'd0);

    // Store strobe held low across reset release must not write.
    mem_oe = 1'b1; addr = BASE; d_in = 8'h77; mem_we = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tx_ok = 1'b1;
    repeat (8) begin tick(); if (tx !== 1'b1) tx_ok = 1'b0; end
    mem_we = 1'b1;
    repeat (20) begin tick(); if (tx !== 1'b1) tx_ok = 1'b0; end
    check("held strobe tx idle", {31'd0, tx_ok}, 32'd1);
    check("held strobe no frame", rx_q.size(), 0);
    check_status("held strobe status", 8'h02);
    tick();

    // Table-driven address decode / read mux.
    tv[0] = '{16'hFF01, 1'b0, 1'b1, 8'h02};
    tv[1] = '{16'hFF00, 1'b0, 1'b1, 8'h00};
    tv[2] = '{16'hFF01, 1'b1, 1'b0, 8'h00};
    tv[3] = '{16'hFF02, 1'b0, 1'b0, 8'h00};
    tv[4] = '{16'hFE01, 1'b0, 1'b0, 8'h00};
    tv[5] = '{16'h7F00, 1'b0, 1'b0, 8'h00};
    tv[6] = '{16'hFF00, 1'b1, 1'b0, 8'h00};
    for (int i = 0; i < 7; i++) begin
      addr = tv[i].a; mem_oe = tv[i].oe;
      #1;
      check($sformatf("decode[%0d] d_oe", i), {31'd0, d_oe}, {31'd0, tv[i].exp_doe});
      if (tv[i].exp_doe) begin
        check($sformatf("decode[%0d] d_out", i), {24'd0, d_out}, {24'd0, tv[i].exp_dout});
      end
      mem_oe = 1'b1;
    end
    tick();

    // Exact per-cycle waveform for 8'hA5.
    rx_q.delete(); rx_t.delete();
    fr_byte = 8'hA5;
    addr = BASE; d_in = fr_byte; mem_we = 1'b0;
    for (int j = 0; j < 44; j++) begin
      tick();
      if (j == 0) mem_we = 1'b1;
      if (j < 3 || j > 42) exp_tx = 1'b1;
      else if ((j - 3) / DIV == 0) exp_tx = 1'b0;
      else if ((j - 3) / DIV == 9) exp_tx = 1'b1;
      else exp_tx = fr_byte[(j - 3) / DIV - 1];
      check($sformatf("A5 tx cycle %0d", j), {31'd0, tx}, {31'd0, exp_tx});
      if (j == 20) check_status("A5 busy mid frame", 8'h06);
    end
    check("A5 frame count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("A5 decoded", {24'd0, rx_q[0]}, 32'hA5);

    // One long strobe yields one frame.
    rx_q.delete(); rx_t.delete();
    bus_write(BASE, 8'h3C, 20);
    repeat (80) tick();
    check("long strobe frame count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("long strobe data", {24'd0, rx_q[0]}, 32'h3C);

    // Six fast writes into a depth-4 FIFO: one popped, four stored, one dropped.
    rx_q.delete(); rx_t.delete();
    for (int i = 1; i <= 6; i++) bus_write(BASE, 8'(i), 1);
    check_status("overflow status", 8'h0D);
    n_acc = (6 < DEPTH + 1) ? 6 : DEPTH + 1;
    wait_rx("burst", n_acc, 600);
    repeat (50) tick();
    check("burst frame count", rx_q.size(), n_acc);
    for (int i = 0; i < n_acc && i < rx_q.size(); i++)
      check($sformatf("burst byte %0d", i), {24'd0, rx_q[i]}, i + 1);
    for (int i = 1; i < rx_t.size(); i++)
      check($sformatf("burst spacing %0d", i), rx_t[i] - rx_t[i-1], 10 * DIV + 1);
    check_status("after burst drain", 8'h0A);
    tick();

    // Interrupt enable, overflow clear, irq follows FIFO fullness.
    bus_write(BASE + 16'd1, 8'h88, 1);
    check_status("status after 88", 8'h82);
    check("irq enabled", {31'd0, irq}, 32'd1);
    tick();
    bus_write(BASE + 16'd1, 8'h80, 1);
    check_status("status after 80", 8'h82);
    tick();
    rx_q.delete(); rx_t.delete();
    for (int i = 0; i < DEPTH + 1; i++) bus_write(BASE, 8'h10 + 8'(i), 1);
    check("irq low when full", {31'd0, irq}, 32'd0);
    check_status("status full", 8'h85);
    wait_rx("irq drain", DEPTH + 1, 600);
    repeat (10) tick();
    check("irq back after drain", {31'd0, irq}, 32'd1);
    check("irq drain count", rx_q.size(), DEPTH + 1);
    check_status("status drained", 8'h82);
    tick();

    // Randomised bursts against a byte-queue model.
    m_ie = 1'b1;
    for (int it = 0; it < 10; it++) begin
      logic [15:0] ra;
      logic [7:0]  rd;
      int          kind;
      rx_q.delete(); rx_t.delete(); exp_q.delete();
      k = $urandom_range(1, 4);
      for (int w = 0; w < k; w++) begin
        kind = $urandom_range(0, 3);
        rd   = 8'($urandom);
        if (kind <= 1) begin
          bus_write(BASE, rd, $urandom_range(1, 5));
          exp_q.push_back(rd);
        end else if (kind == 2) begin
          ra = 16'($urandom);
          if (ra[15:1] == BASE[15:1]) ra[8] = ~ra[8];
          bus_write(ra, rd, $urandom_range(1, 5));
        end else begin
          bus_write(BASE + 16'd1, rd, $urandom_range(1, 5));
          m_ie = rd[7];
        end
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_rx($sformatf("random %0d", it), exp_q.size(), 300);
      repeat (45) tick();
      check($sformatf("random %0d count", it), rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
        check($sformatf("random %0d byte %0d", it, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
      check_status($sformatf("random %0d status", it), {m_ie, 7'b0000010});
      check($sformatf("random %0d irq", it), {31'd0, irq}, {31'd0, m_ie});
      tick();
    end

    // Reset in the middle of a data bit.
    rx_q.delete(); rx_t.delete();
    addr = BASE; d_in = 8'h00; mem_we = 1'b0;
    tick();
    mem_we = 1'b1;
    repeat (3 + DIV + DIV / 2) tick();
    check("mid data tx low", {31'd0, tx}, 32'd0);
    rst = 1'b0;
    tick();
    check("reset mid frame tx", {31'd0, tx}, 32'd1);
    check_status("reset mid frame status", 8'h02);
    check("reset mid frame irq", {31'd0, irq}, 32'd0);
    tick();
    rst = 1'b1;
    repeat (50) tick();
    rx_q.delete(); rx_t.delete();
    bus_write(BASE, 8'h5A, 1);
    wait_rx("post reset", 1, 100);
    repeat (5) tick();
    check("post reset count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("post reset data", {24'd0, rx_q[0]}, 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
